// File: rtl/mem_arbiter.sv
// Two-master (I-cache, D-cache) to one-slave Wishbone arbiter.
// One cache owns memory for a whole line transfer. The owner's ack/rty are
// forwarded only to it. Simultaneous requests are resolved round-robin
// against the last master served. At least one idle bus cycle separates
// transactions.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    // I-cache port
    input  logic              i_cyc,
    input  logic              i_stb,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_adr,
    input  logic [DATA_W-1:0] i_dat_w,
    output logic              i_ack,
    output logic              i_rty,
    // D-cache port
    input  logic              d_cyc,
    input  logic              d_stb,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_adr,
    input  logic [DATA_W-1:0] d_dat_w,
    output logic              d_ack,
    output logic              d_rty,
    // read data broadcast to both caches
    output logic [DATA_W-1:0] dat_r,
    // memory port
    output logic              mem_cyc,
    output logic              mem_stb,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_dat_w,
    input  logic              mem_ack,
    input  logic              mem_rty,
    input  logic [DATA_W-1:0] mem_dat_r
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // r_last: master that most recently finished (1'b0 = I, 1'b1 = D)
    state_t r_state;
    state_t w_state_nxt;
    logic   r_last;
    logic   w_last_nxt;

    logic   w_req_i;
    logic   w_req_d;
    logic   w_term;

    assign w_req_i = i_cyc & i_stb;
    assign w_req_d = d_cyc & d_stb;
    // ack and rty together are a single termination
    assign w_term  = mem_ack | mem_rty;

    // Memory read data goes to both caches; each qualifies it with its own ack
    assign dat_r = mem_dat_r;

    // Grant state and round-robin history registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Arbitration, grant exit and combinational routing of the granted master
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        mem_cyc     = 1'b0;
        mem_stb     = 1'b0;
        mem_we      = 1'b0;
        mem_adr     = {ADDR_W{1'b0}};
        mem_dat_w   = {DATA_W{1'b0}};
        i_ack       = 1'b0;
        i_rty       = 1'b0;
        d_ack       = 1'b0;
        d_rty       = 1'b0;

        case (r_state)
            ST_IDLE, ST_GAP: begin
                // Stray mem_ack/mem_rty here are dropped by the defaults above
                if (w_req_i && w_req_d) begin
                    // Tie: serve whichever master did not go last
                    if (r_last) begin
                        w_state_nxt = ST_GNT_I;
                    end else begin
                        w_state_nxt = ST_GNT_D;
                    end
                end else if (w_req_i) begin
                    w_state_nxt = ST_GNT_I;
                end else if (w_req_d) begin
                    w_state_nxt = ST_GNT_D;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_GNT_I: begin
                mem_cyc   = i_cyc;
                mem_stb   = i_stb;
                mem_we    = i_we;
                mem_adr   = i_adr;
                mem_dat_w = i_dat_w;
                i_ack     = mem_ack;
                i_rty     = mem_rty;
                // Completion or abort (cyc dropped) both release the bus
                if (w_term || !i_cyc) begin
                    w_state_nxt = ST_GAP;
                    w_last_nxt  = 1'b0;
                end else begin
                    w_state_nxt = ST_GNT_I;
                end
            end

            ST_GNT_D: begin
                mem_cyc   = d_cyc;
                mem_stb   = d_stb;
                mem_we    = d_we;
                mem_adr   = d_adr;
                mem_dat_w = d_dat_w;
                d_ack     = mem_ack;
                d_rty     = mem_rty;
                if (w_term || !d_cyc) begin
                    w_state_nxt = ST_GAP;
                    w_last_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_GNT_D;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_last_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by
// randomized masters and memory, compared every cycle to a bus-ownership model.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_cyc, i_stb, i_we;
    logic [ADDR_W-1:0] i_adr;
    logic [DATA_W-1:0] i_dat_w;
    logic              i_ack, i_rty;
    logic              d_cyc, d_stb, d_we;
    logic [ADDR_W-1:0] d_adr;
    logic [DATA_W-1:0] d_dat_w;
    logic              d_ack, d_rty;
    logic [DATA_W-1:0] dat_r;
    logic              mem_cyc, mem_stb, mem_we;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_dat_w;
    logic              mem_ack, mem_rty;
    logic [DATA_W-1:0] mem_dat_r;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr), .i_dat_w(i_dat_w),
        .i_ack(i_ack), .i_rty(i_rty),
        .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr), .d_dat_w(d_dat_w),
        .d_ack(d_ack), .d_rty(d_rty),
        .dat_r(dat_r),
        .mem_cyc(mem_cyc), .mem_stb(mem_stb), .mem_we(mem_we), .mem_adr(mem_adr),
        .mem_dat_w(mem_dat_w), .mem_ack(mem_ack), .mem_rty(mem_rty), .mem_dat_r(mem_dat_r)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the bus (0 none, 1 I-cache, 2 D-cache) and who went last
    int m_owner  = 0;
    bit m_last_d = 1'b0;
    bit got_i    = 1'b0;
    bit got_d    = 1'b0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against what the current owner implies
    task automatic check_all();
        logic              e_cyc, e_stb, e_we, e_iack, e_irty, e_dack, e_drty;
        logic [ADDR_W-1:0] e_adr;
        logic [DATA_W-1:0] e_dat;
        if (!rst_n) begin
            m_owner  = 0;
            m_last_d = 1'b0;
        end
        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0;
        e_iack = 1'b0; e_irty = 1'b0; e_dack = 1'b0; e_drty = 1'b0;
        if (m_owner == 1) begin
            e_cyc = i_cyc; e_stb = i_stb; e_we = i_we; e_adr = i_adr; e_dat = i_dat_w;
            e_iack = mem_ack; e_irty = mem_rty;
        end else if (m_owner == 2) begin
            e_cyc = d_cyc; e_stb = d_stb; e_we = d_we; e_adr = d_adr; e_dat = d_dat_w;
            e_dack = mem_ack; e_drty = mem_rty;
        end
        chk("mem_cyc",   128'(mem_cyc),   128'(e_cyc));
        chk("mem_stb",   128'(mem_stb),   128'(e_stb));
        chk("mem_we",    128'(mem_we),    128'(e_we));
        chk("mem_adr",   128'(mem_adr),   128'(e_adr));
        chk("mem_dat_w", mem_dat_w,       e_dat);
        chk("i_ack",     128'(i_ack),     128'(e_iack));
        chk("i_rty",     128'(i_rty),     128'(e_irty));
        chk("d_ack",     128'(d_ack),     128'(e_dack));
        chk("d_rty",     128'(d_rty),     128'(e_drty));
        chk("dat_r",     dat_r,           mem_dat_r);
    endtask

    // Advance the ownership model by one clock edge
    task automatic model_update();
        bit term, own_cyc, ri, rd;
        got_i = 1'b0;
        got_d = 1'b0;
        if (!rst_n) begin
            m_owner  = 0;
            m_last_d = 1'b0;
        end else if (m_owner != 0) begin
            term    = mem_ack | mem_rty;
            own_cyc = (m_owner == 1) ? i_cyc : d_cyc;
            if (term) begin
                got_i = (m_owner == 1);
                got_d = (m_owner == 2);
            end
            if (term || !own_cyc) begin
                m_last_d = (m_owner == 2);
                m_owner  = 0;
            end
        end else begin
            ri = i_cyc & i_stb;
            rd = d_cyc & d_stb;
            if (ri && rd)  m_owner = m_last_d ? 1 : 2;
            else if (ri)   m_owner = 1;
            else if (rd)   m_owner = 2;
            else           m_owner = 0;
        end
    endtask

    // Inputs are set at the falling edge; check, then advance over the rising edge
    task automatic tick();
        #1 check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    bit ai, ad;

    initial begin
        rst_n = 1'b0;
        i_cyc = 1'b0; i_stb = 1'b0; i_we = 1'b0; i_adr = '0; i_dat_w = '0;
        d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0; d_adr = '0; d_dat_w = '0;
        mem_ack = 1'b0; mem_rty = 1'b0; mem_dat_r = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        @(negedge clk);

        // T1: reset with both requesting, then D wins the first tie
        i_cyc = 1'b1; i_stb = 1'b1; i_adr = 32'h0000_0040; i_dat_w = 128'h11;
        d_cyc = 1'b1; d_stb = 1'b1; d_adr = 32'h0000_0080; d_dat_w = 128'h22;
        mem_ack = 1'b1;
        #1 chk("t1_rst_mem_cyc", 128'(mem_cyc), 128'(1'b0));
        chk("t1_rst_i_ack", 128'(i_ack), 128'(1'b0));
        tick();
        mem_ack = 1'b0;
        rst_n = 1'b1;
        tick();
        #1 chk("t1_gnt_d_adr", 128'(mem_adr), 128'(32'h0000_0080));
        chk("t1_gnt_d_cyc", 128'(mem_cyc), 128'(1'b1));
        tick();
        mem_ack = 1'b1;
        tick();
        // T3: I has been waiting; it is served right after the gap
        mem_ack = 1'b0;
        tick();
        #1 chk("t3_gnt_i_adr", 128'(mem_adr), 128'(32'h0000_0040));
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; i_cyc = 1'b0; i_stb = 1'b0;
        tick();
        tick();
        d_cyc = 1'b0; d_stb = 1'b0;
        tick();

        // T2: single I read at 0x100
        i_cyc = 1'b1; i_stb = 1'b1; i_we = 1'b0; i_adr = 32'h0000_0100;
        tick();
        #1 chk("t2_adr", 128'(mem_adr), 128'(32'h0000_0100));
        chk("t2_cyc", 128'(mem_cyc), 128'(1'b1));
        tick(); tick(); tick();
        mem_ack = 1'b1;
        #1 chk("t2_i_ack", 128'(i_ack), 128'(1'b1));
        chk("t2_d_ack", 128'(d_ack), 128'(1'b0));
        tick();
        mem_ack = 1'b0; i_cyc = 1'b0; i_stb = 1'b0;
        #1 chk("t2_gap_cyc", 128'(mem_cyc), 128'(1'b0));
        tick();

        // T5: abort drops mem_cyc in the same cycle; stray acks are not forwarded
        i_cyc = 1'b1; i_stb = 1'b1; i_adr = 32'h0000_0200;
        tick(); tick();
        i_cyc = 1'b0; i_stb = 1'b0;
        #1 chk("t5_abort_cyc", 128'(mem_cyc), 128'(1'b0));
        tick();
        mem_ack = 1'b1;
        #1 chk("t5_stray_i_ack", 128'(i_ack), 128'(1'b0));
        chk("t5_stray_d_ack", 128'(d_ack), 128'(1'b0));
        tick();
        tick();
        mem_ack = 1'b0;

        // T6: retry to D, then D retries and completes
        d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b0; d_adr = 32'h0000_0300;
        tick();
        mem_rty = 1'b1;
        #1 chk("t6_d_rty", 128'(d_rty), 128'(1'b1));
        chk("t6_i_rty", 128'(i_rty), 128'(1'b0));
        tick();
        mem_rty = 1'b0;
        #1 chk("t6_gap_cyc", 128'(mem_cyc), 128'(1'b0));
        tick();
        mem_ack = 1'b1;
        #1 chk("t6_d_ack", 128'(d_ack), 128'(1'b1));
        tick();
        mem_ack = 1'b0; d_cyc = 1'b0; d_stb = 1'b0;
        tick();

        // Randomized masters and memory, with a reset in the middle
        ai = 1'b0; ad = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (got_i || (ai && $urandom_range(0, 39) == 0)) begin
                ai = 1'b0;
            end else if (!ai && $urandom_range(0, 2) == 0) begin
                ai = 1'b1;
                i_adr = $urandom & 32'hFFFF_FFF0;
                i_we = 1'($urandom_range(0, 1));
                i_dat_w = {$urandom, $urandom, $urandom, $urandom};
            end
            if (got_d || (ad && $urandom_range(0, 39) == 0)) begin
                ad = 1'b0;
            end else if (!ad && $urandom_range(0, 2) == 0) begin
                ad = 1'b1;
                d_adr = $urandom & 32'hFFFF_FFF0;
                d_we = 1'($urandom_range(0, 1));
                d_dat_w = {$urandom, $urandom, $urandom, $urandom};
            end
            if (cyc == 1500 || cyc == 1501) begin
                rst_n = 1'b0;
                ai = 1'b0;
                ad = 1'b0;
            end else begin
                rst_n = 1'b1;
            end
            i_cyc = ai;
            i_stb = ai & ($urandom_range(0, 9) != 0);
            d_cyc = ad;
            d_stb = ad & ($urandom_range(0, 9) != 0);
            mem_ack = ($urandom_range(0, 3) == 0);
            mem_rty = ($urandom_range(0, 11) == 0);
            mem_dat_r = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
